instr_cache: RTL and testbench
==============================

Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the 16-byte-block instruction memory.
- Takes 10-bit byte PCs from the CPU and returns 32-bit instructions. Returns in the same cycle on a hit.
- On a miss it becomes the initiator of the block-read handshake to instr_memory (read / 6-bit block address / 128-bit readdata / busywait) and stalls the CPU until the line is filled.

Parameters:
- NUM_LINES, 8, number of cache lines (index width = log2(NUM_LINES) = 3)
- ADDR_W, 10, CPU byte-address width
- BLOCK_W, 128, line / memory block width in bits
- WORD_W, 32, instruction width

Ports:
- clock  input  1  system clock, all state updates on posedge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- cpu_read  input  1  CPU fetch request, held high while the CPU wants an instruction
- cpu_address  input  10  PC byte address; [9:7] tag, [6:4] index, [3:2] word offset, [1:0] ignored
- cpu_instruction  output  32  selected instruction word
- cpu_busywait  output  1  CPU stall
- mem_read  output  1  block read request to instruction memory
- mem_address  output  6  block address {tag, index}
- mem_readdata  input  128  block from memory; byte 0 in [7:0], word w in [32w+31:32w]
- mem_busywait  input  1  memory busy

Behaviour:
- Storage: per line one valid bit, a 3-bit tag and 128 data bits. Reset clears all valid bits. Tag and data are don't-care after reset.
- hit = cpu_read & valid[index] & (tag[index] == cpu_address[9:7]). This is combinational.
- cpu_instruction = data[index] word selected by cpu_address[3:2]. It is combinational and is a don't-care when hit=0.
- cpu_busywait:
  - In IDLE it equals cpu_read & ~hit (combinational).
  - In MEM_READ and UPDATE it is 1.
  - It is 0 when cpu_read=0 in IDLE.
- FSM state register, reset to IDLE:
  - IDLE: mem_read=0, mem_address=0. On a posedge with cpu_read & ~hit, go to MEM_READ and latch {tag, index} into mem_address.
  - MEM_READ: mem_read=1, mem_address held stable. A seen_busy flag sets on any posedge with mem_busywait=1. Go to UPDATE on the first posedge where seen_busy=1 and mem_busywait=0. mem_readdata is valid at that edge; capture it into a fill register.
  - UPDATE: mem_read=0. On the posedge: data[index] <= fill, tag[index] <= latched tag, valid[index] <= 1, seen_busy <= 0, next state IDLE.
  - Back in IDLE the same PC now hits and cpu_busywait falls combinationally.
- Miss penalty: 2 cycles (MEM_READ entry + UPDATE) plus the memory busy time, at minimum 1 + memory latency + 1 cycles.
- Index and tag used for the fill are the latched values, not the live cpu_address. A PC change during a fill does not corrupt the line.
- A different tag at a valid index evicts the old line. There is no writeback (read-only).
- cpu_read falling mid-fill: the fill still completes and the line is installed.
- Reset mid-operation (any state):
  - Immediate return to IDLE, mem_read=0, all valid=0, seen_busy=0.
  - cpu_busywait then follows the IDLE rule.
- Reset values of outputs (reset low, cpu_read=0): cpu_busywait=0, mem_read=0, mem_address=0, cpu_instruction=don't-care (drive 0 when no line valid).
- There are no timing delays (#) in RTL. Simulation-only delays, if any, stay in the testbench.

Decomposition:
- Shared package icache_pkg:
  - Width constants ADDR_W, TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W, WORD_W, MEM_ADDR_W=6.
  - State enum {IDLE, MEM_READ, UPDATE}.
  - Field-slice helpers (tag/index/offset of an address).
- One natural sub-module, icache_line_store:
  - Valid/tag/data arrays with async clear of valid.
  - One write port (index, tag, data, we).
  - Combinational read port returning valid, tag and data at an index.
- The FSM, hit compare and word mux stay in instr_cache.

Test Plan:
- Reset then cold miss: memory model word0=0x00010006, latency 5 cycles. cpu_read=1, cpu_address=0x000 -> cpu_busywait=1 immediately, mem_read=1 with mem_address=0 held until busy falls. Line installed in UPDATE, then cpu_instruction=0x00010006 and cpu_busywait=0.
- Same-line hits: cpu_address=0x004, 0x008, 0x00C after the fill -> zero-stall hits, returning words 1, 2, 3 of block 0, with mem_read never asserted.
- Conflict eviction: fill block 0 (addr 0x000), then 0x080 (tag 1, index 0) -> miss with mem_address=0x08. A return to 0x000 misses again (mem_address=0x00).
- Distinct indices: fill 0x000 and 0x010 -> both resident, and alternating fetches hit with no mem_read.
- PC change mid-fill: start a miss on 0x020, switch cpu_address to 0x3F0 during MEM_READ -> index 2 gets tag 0 block 0x02 data. 0x3F0 then misses with mem_address=0x3F.
- Reset mid-fill: assert reset during MEM_READ -> mem_read=0 and cpu_busywait=0 with cpu_read=0. After release, a re-fetch of 0x000 misses (valid cleared).

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the width constants, the controller state encoding and the helpers that
// split a CPU byte address into tag / index / word-offset fields.
package icache_pkg;

  localparam int unsigned NUM_LINES  = 8;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned INDEX_W    = 3;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MEM_ADDR_W = TAG_W + INDEX_W;

  // Address layout: [9:7] tag, [6:4] index, [3:2] word offset, [1:0] byte (ignored).
  localparam int unsigned OFFSET_LSB = 2;
  localparam int unsigned INDEX_LSB  = OFFSET_LSB + OFFSET_W;

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StUpdate
  } icache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_LSB +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_LSB +: OFFSET_W];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid / tag / data storage for the instruction cache.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset (clears every valid bit)
//   we_i                    install a line at wr_index_i
//   wr_index_i/tag_i/data_i line being installed
//   rd_index_i              combinational read index
//   rd_valid_o/tag_o/data_o contents of the line at rd_index_i
module icache_line_store #(
  parameter int unsigned NumLines = 8,
  parameter int unsigned TagW     = 3,
  parameter int unsigned DataW    = 128,
  localparam int unsigned IndexW  = $clog2(NumLines)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IndexW-1:0] wr_index_i,
  input  logic [TagW-1:0]   wr_tag_i,
  input  logic [DataW-1:0]  wr_data_i,
  input  logic [IndexW-1:0] rd_index_i,
  output logic              rd_valid_o,
  output logic [TagW-1:0]   rd_tag_o,
  output logic [DataW-1:0]  rd_data_o
);

  logic [NumLines-1:0] valid_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [DataW-1:0]    data_q [NumLines];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache.
// Hits return the instruction in the same cycle; a miss stalls the CPU, fetches
// the 16-byte block from instruction memory and installs it.
// Ports:
//   clock, reset                   clock, async active-low reset
//   cpu_read, cpu_address          fetch request and byte PC
//   cpu_instruction, cpu_busywait  selected word and CPU stall
//   mem_read, mem_address          block read request and block address {tag, index}
//   mem_readdata, mem_busywait     block data and memory busy
module instr_cache
  import icache_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic [ADDR_W-1:0]     cpu_address,
  output logic [WORD_W-1:0]     cpu_instruction,
  output logic                  cpu_busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
);

  icache_state_e         state_q;
  logic                  mem_read_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic                  seen_busy_q;
  logic [BLOCK_W-1:0]    fill_q;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [BLOCK_W-1:0] rd_data;
  logic               hit;
  logic               line_we;

  // Fills use the latched {tag, index}, so a PC change mid-fill cannot corrupt a line.
  assign line_we = (state_q == StUpdate);

  icache_line_store #(
    .NumLines (NUM_LINES),
    .TagW     (TAG_W),
    .DataW    (BLOCK_W)
  ) u_line_store (
    .clk_i      (clock),
    .rst_ni     (reset),
    .we_i       (line_we),
    .wr_index_i (mem_addr_q[INDEX_W-1:0]),
    .wr_tag_i   (mem_addr_q[MEM_ADDR_W-1 -: TAG_W]),
    .wr_data_i  (fill_q),
    .rd_index_i (addr_index(cpu_address)),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data)
  );

  assign hit = cpu_read & rd_valid & (rd_tag == addr_tag(cpu_address));

  // Gate by valid so an empty line reads as zero instead of uninitialised data.
  assign cpu_instruction = rd_valid ? rd_data[{addr_offset(cpu_address), 5'b0} +: WORD_W]
                                    : '0;

  assign cpu_busywait = (state_q == StIdle) ? (cpu_read & ~hit) : 1'b1;
  assign mem_read     = mem_read_q;
  assign mem_address  = mem_addr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      seen_busy_q <= 1'b0;
      fill_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_read && !hit) begin
            state_q    <= StMemRead;
            mem_read_q <= 1'b1;
            mem_addr_q <= {addr_tag(cpu_address), addr_index(cpu_address)};
          end
        end
        StMemRead: begin
          if (mem_busywait) begin
            seen_busy_q <= 1'b1;
          end
          // Data is valid on the first edge after busy has been seen and has dropped.
          if (seen_busy_q && !mem_busywait) begin
            fill_q     <= mem_readdata;
            mem_read_q <= 1'b0;
            state_q    <= StUpdate;
          end
        end
        StUpdate: begin
          seen_busy_q <= 1'b0;
          mem_addr_q  <= '0;
          state_q     <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;
  import icache_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  cpu_read = 1'b0;
  logic [ADDR_W-1:0]     cpu_address = '0;
  logic [WORD_W-1:0]     cpu_instruction;
  logic                  cpu_busywait;
  logic                  mem_read;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [BLOCK_W-1:0]    mem_readdata = '0;
  logic                  mem_busywait = 1'b0;

  int errors = 0;
  int checks = 0;
  int mr_cycles = 0;

  instr_cache dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_read        (cpu_read),
    .cpu_address     (cpu_address),
    .cpu_instruction (cpu_instruction),
    .cpu_busywait    (cpu_busywait),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .mem_readdata    (mem_readdata),
    .mem_busywait    (mem_busywait)
  );

  always #5 clock = ~clock;

  // Block b, word w holds 0x00010006 + (b << 24) + (w << 16).
  function automatic logic [BLOCK_W-1:0] block_of(input logic [MEM_ADDR_W-1:0] b);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      r[32*w +: 32] = 32'h0001_0006 + ({26'b0, b} << 24) + (32'(w) << 16);
    end
    return r;
  endfunction

  // Memory model: busy for 4 cycles starting the edge after mem_read is seen, then data.
  logic active = 1'b0;
  int   cnt = 0;
  always @(posedge clock) begin
    if (mem_read) mr_cycles <= mr_cycles + 1;
    if (!mem_read) begin
      active       <= 1'b0;
      mem_busywait <= 1'b0;
    end else if (!active) begin
      active       <= 1'b1;
      mem_busywait <= 1'b1;
      cnt          <= 4;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mem_busywait <= 1'b0;
        mem_readdata <= block_of(mem_address);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Waits until the stall clears; returns the number of negedges waited.
  task automatic wait_fill(input string tag, output int n);
    n = 0;
    while (cpu_busywait && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 60), 32'd1);
  endtask

  task automatic wait_mem_read_low(input string tag);
    int n;
    n = 0;
    while (mem_read && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 60), 32'd1);
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    @(negedge clock);
    cpu_read    = 1'b1;
    cpu_address = a;
    #1;
  endtask

  initial begin
    int n;
    int snap;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_busywait", 32'(cpu_busywait), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_instr", cpu_instruction, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Cold miss on 0x000
    fetch(10'h000);
    check("cold_busy_now", 32'(cpu_busywait), 32'd1);
    check("cold_mr_not_yet", 32'(mem_read), 32'd0);
    @(negedge clock);
    #1;
    check("cold_mem_read", 32'(mem_read), 32'd1);
    check("cold_mem_addr", 32'(mem_address), 32'h00);
    n = 0;
    while (mem_read && n < 60) begin
      check("cold_addr_held", 32'(mem_address), 32'h00);
      @(negedge clock);
      #1;
      n++;
    end
    wait_fill("cold_fill", n);
    check("cold_instr", cpu_instruction, 32'h0001_0006);
    check("cold_busy_done", 32'(cpu_busywait), 32'd0);

    // Same-line hits
    snap = mr_cycles;
    fetch(10'h004);
    check("hit_w1", cpu_instruction, 32'h0002_0006);
    check("hit_w1_busy", 32'(cpu_busywait), 32'd0);
    fetch(10'h008);
    check("hit_w2", cpu_instruction, 32'h0003_0006);
    check("hit_w2_busy", 32'(cpu_busywait), 32'd0);
    fetch(10'h00C);
    check("hit_w3", cpu_instruction, 32'h0004_0006);
    @(negedge clock);
    #1;
    check("hit_no_mem_read", 32'(mr_cycles - snap), 32'd0);

    // Conflict eviction: tag 1, index 0
    fetch(10'h080);
    check("evict_busy", 32'(cpu_busywait), 32'd1);
    wait_fill("evict_fill", n);
    check("evict_stall_cycles", 32'(n), 32'd8);
    check("evict_instr", cpu_instruction, 32'h0801_0006);
    fetch(10'h000);
    check("evict_back_busy", 32'(cpu_busywait), 32'd1);
    @(negedge clock);
    #1;
    check("evict_back_addr", 32'(mem_address), 32'h00);
    wait_fill("evict_back_fill", n);
    check("evict_back_instr", cpu_instruction, 32'h0001_0006);

    // Distinct indices both resident
    fetch(10'h010);
    wait_fill("idx1_fill", n);
    check("idx1_instr", cpu_instruction, 32'h0101_0006);
    snap = mr_cycles;
    fetch(10'h000);
    check("alt0_busy", 32'(cpu_busywait), 32'd0);
    check("alt0_instr", cpu_instruction, 32'h0001_0006);
    fetch(10'h014);
    check("alt1_busy", 32'(cpu_busywait), 32'd0);
    check("alt1_instr", cpu_instruction, 32'h0102_0006);
    fetch(10'h00C);
    check("alt2_instr", cpu_instruction, 32'h0004_0006);
    @(negedge clock);
    #1;
    check("alt_no_mem_read", 32'(mr_cycles - snap), 32'd0);

    // PC change mid-fill
    fetch(10'h020);
    @(negedge clock);
    cpu_address = 10'h3F0;
    #1;
    check("pcchg_mem_addr", 32'(mem_address), 32'h02);
    wait_mem_read_low("pcchg_drop");
    @(negedge clock);
    #1;
    check("pcchg_new_miss", 32'(cpu_busywait), 32'd1);
    @(negedge clock);
    #1;
    check("pcchg_new_mr", 32'(mem_read), 32'd1);
    check("pcchg_new_addr", 32'(mem_address), 32'h3F);
    wait_fill("pcchg_fill", n);
    check("pcchg_3f_instr", cpu_instruction, 32'h3F01_0006);
    fetch(10'h020);
    check("pcchg_old_busy", 32'(cpu_busywait), 32'd0);
    check("pcchg_old_instr", cpu_instruction, 32'h0201_0006);

    // Reset mid-fill
    fetch(10'h100);
    @(negedge clock);
    #1;
    check("rstmid_mr_before", 32'(mem_read), 32'd1);
    reset    = 1'b0;
    cpu_read = 1'b0;
    #1;
    check("rstmid_mem_read", 32'(mem_read), 32'd0);
    check("rstmid_busy", 32'(cpu_busywait), 32'd0);
    check("rstmid_addr", 32'(mem_address), 32'h00);
    @(negedge clock);
    reset = 1'b1;
    fetch(10'h000);
    check("rstmid_refetch_miss", 32'(cpu_busywait), 32'd1);
    @(negedge clock);
    #1;
    check("rstmid_refetch_addr", 32'(mem_address), 32'h00);
    wait_fill("rstmid_fill", n);
    check("rstmid_instr", cpu_instruction, 32'h0001_0006);

    @(negedge clock);
    cpu_read = 1'b0;
    #1;
    check("idle_no_read_busy", 32'(cpu_busywait), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
